// File: rtl/lsu_rmw_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : lsu_rmw_ctrl
// Brief   : RV32I load/store sequencer for a word-only memory; SB/SH are done
//           as read-modify-write, LB/LH/LBU/LHU are extended on return.
// Revision: 1.0
// ============================================================================
module lsu_rmw_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  ready,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_A,
    output logic [DATA_WIDTH-1:0] mem_WD,
    output logic                  mem_WE,
    input  logic [DATA_WIDTH-1:0] mem_RD
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [2:0]            f3_q, f3_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;

    logic                  w_illegal;
    logic                  w_misaligned;
    logic [DATA_WIDTH-1:0] w_load_ext;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;

    // funct3 011/110/111 are never legal; unsigned widths exist only for loads
    assign w_illegal    = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)
                       || (req_we && req_funct3[2]);
    assign w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                       || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    always_comb begin
        w_byte     = mem_RD[{addr_q[1:0], 3'b000} +: 8];
        w_half     = mem_RD[{addr_q[1], 4'b0000} +: 16];
        w_load_ext = mem_RD;
        case (f3_q)
            3'b000:  w_load_ext = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_ext = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            3'b100:  w_load_ext = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            3'b101:  w_load_ext = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: w_load_ext = mem_RD;
        endcase
    end

    // Merge is driven continuously so mem_WD is a pure function of held state
    always_comb begin
        w_merged = word_q;
        if (f3_q[1:0] == 2'b00) begin
            w_merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else if (f3_q[1:0] == 2'b01) begin
            w_merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end else begin
            w_merged = wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        f3_d    = f3_q;
        we_d    = we_q;
        err_d   = err_q;
        ready   = 1'b0;
        done    = 1'b0;
        mem_WE  = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    f3_d    = req_funct3;
                    we_d    = req_we;
                    if (w_illegal || w_misaligned) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (!req_we) begin
                        state_d = S_LOAD;
                    end else if (req_funct3 == 3'b010) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_LOAD: begin
                rdata_d = w_load_ext;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_READ: begin
                word_d  = mem_RD;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                mem_WE  = 1'b1;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_RESP: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            f3_q    <= 3'b000;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    assign err    = err_q;
    assign rdata  = rdata_q;
    assign mem_A  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign mem_WD = w_merged;

endmodule
`default_nettype wire

// File: tb/tb_lsu_rmw_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_rmw_ctrl
// Brief   : Directed self-checking bench for lsu_rmw_ctrl with a word memory.
// Revision: 1.0
// ============================================================================
module tb_lsu_rmw_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        ready, done, err, mem_WE;
    logic [31:0] rdata, mem_A, mem_WD, mem_RD;

    logic [31:0] mem [0:15];
    int          we_cnt = 0;
    logic [31:0] last_A = 32'd0;
    logic [31:0] last_WD = 32'd0;
    int          n_checks = 0;
    int          n_fail = 0;

    lsu_rmw_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .ready(ready), .done(done), .err(err), .rdata(rdata),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
    );

    always #5 CLK = ~CLK;

    assign mem_RD = mem[mem_A[5:2]];

    always @(posedge CLK) begin
        if (mem_WE) begin
            mem[mem_A[5:2]] = mem_WD;
            we_cnt  = we_cnt + 1;
            last_A  = mem_A;
            last_WD = mem_WD;
        end
    end

    // Presents one request, returns after the done cycle with the latency in cycles
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat);
        @(negedge CLK);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge CLK);
        #1;
        req_valid = 1'b0; req_wdata = 32'hDEAD_0000; req_addr = 32'hFFFF_FFFF;
        lat = 1;
        @(negedge CLK);
        while (done !== 1'b1 && lat < 10) begin
            @(negedge CLK);
            lat++;
        end
        if (done !== 1'b1) lat = 99;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rdata); end
        n_checks++; if (mem_WE !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", mem_WE); end
        n_checks++; if (mem_A !== 32'd0 || mem_WD !== 32'd0) begin
            n_fail++; $display("FAIL reset_bus got A=%h WD=%h want 0/0", mem_A, mem_WD); end
        RST = 1'b0;
    endtask

    task automatic test_sw_lw();
        int lat; int w0;
        w0 = we_cnt;
        issue(1'b1, 3'b010, 32'd4, 32'd22, lat);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sw_latency got %0d want 2", lat); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL sw_err got %b want 0", err); end
        n_checks++; if (we_cnt - w0 !== 1 || last_A !== 32'd4 || last_WD !== 32'd22) begin
            n_fail++; $display("FAIL sw_write got n=%0d A=%h WD=%h want 1/4/16", we_cnt - w0, last_A, last_WD); end
        issue(1'b0, 3'b010, 32'd4, 32'd0, lat);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL lw_latency got %0d want 2", lat); end
        n_checks++; if (rdata !== 32'd22) begin n_fail++; $display("FAIL lw_rdata got %h want 16", rdata); end
    endtask

    task automatic test_sb_rmw();
        int lat; int w0;
        mem[1] = 32'h1122_3344;
        w0 = we_cnt;
        issue(1'b1, 3'b000, 32'd5, 32'h0000_00AB, lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL sb_latency got %0d want 3", lat); end
        n_checks++; if (we_cnt - w0 !== 1 || last_WD !== 32'h1122_AB44 || last_A !== 32'd4) begin
            n_fail++; $display("FAIL sb_merge got n=%0d A=%h WD=%h want 1/4/1122ab44", we_cnt - w0, last_A, last_WD); end
        issue(1'b1, 3'b001, 32'd6, 32'h1234_BEEF, lat);
        n_checks++; if (lat !== 3 || mem[1] !== 32'hBEEF_AB44) begin
            n_fail++; $display("FAIL sh_merge got lat=%0d mem=%h want 3/beefab44", lat, mem[1]); end
        n_checks++; if (rdata !== 32'd22) begin n_fail++; $display("FAIL store_keeps_rdata got %h want 16", rdata); end
    endtask

    task automatic test_loads();
        int lat;
        mem[1] = 32'h80FF_7F01;
        issue(1'b0, 3'b000, 32'd6, 32'd0, lat);
        n_checks++; if (rdata !== 32'hFFFF_FFFF || lat !== 2) begin
            n_fail++; $display("FAIL lb_6 got %h lat=%0d want ffffffff/2", rdata, lat); end
        issue(1'b0, 3'b100, 32'd7, 32'd0, lat);
        n_checks++; if (rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_7 got %h want 00000080", rdata); end
        issue(1'b0, 3'b001, 32'd6, 32'd0, lat);
        n_checks++; if (rdata !== 32'hFFFF_80FF) begin n_fail++; $display("FAIL lh_6 got %h want ffff80ff", rdata); end
        issue(1'b0, 3'b101, 32'd6, 32'd0, lat);
        n_checks++; if (rdata !== 32'h0000_80FF) begin n_fail++; $display("FAIL lhu_6 got %h want 000080ff", rdata); end
        issue(1'b0, 3'b000, 32'd5, 32'd0, lat);
        n_checks++; if (rdata !== 32'h0000_007F) begin n_fail++; $display("FAIL lb_5 got %h want 0000007f", rdata); end
        issue(1'b0, 3'b001, 32'd4, 32'd0, lat);
        n_checks++; if (rdata !== 32'h0000_7F01) begin n_fail++; $display("FAIL lh_4 got %h want 00007f01", rdata); end
    endtask

    task automatic test_errors();
        int lat; int w0;
        w0 = we_cnt;
        issue(1'b1, 3'b001, 32'd3, 32'h5555, lat);
        n_checks++; if (lat !== 1 || err !== 1'b1) begin
            n_fail++; $display("FAIL sh_misaligned got lat=%0d err=%b want 1/1", lat, err); end
        issue(1'b0, 3'b010, 32'd2, 32'd0, lat);
        n_checks++; if (lat !== 1 || err !== 1'b1) begin
            n_fail++; $display("FAIL lw_misaligned got lat=%0d err=%b want 1/1", lat, err); end
        issue(1'b0, 3'b011, 32'd4, 32'd0, lat);
        n_checks++; if (lat !== 1 || err !== 1'b1) begin
            n_fail++; $display("FAIL f3_011 got lat=%0d err=%b want 1/1", lat, err); end
        issue(1'b1, 3'b100, 32'd4, 32'h77, lat);
        n_checks++; if (lat !== 1 || err !== 1'b1) begin
            n_fail++; $display("FAIL store_bu got lat=%0d err=%b want 1/1", lat, err); end
        n_checks++; if (we_cnt - w0 !== 0 || rdata !== 32'h0000_7F01) begin
            n_fail++; $display("FAIL err_no_access got writes=%0d rdata=%h want 0/00007f01", we_cnt - w0, rdata); end
        issue(1'b0, 3'b010, 32'd4, 32'd0, lat);
        n_checks++; if (err !== 1'b0 || rdata !== 32'h80FF_7F01) begin
            n_fail++; $display("FAIL err_clears got err=%b rdata=%h want 0/80ff7f01", err, rdata); end
    endtask

    task automatic test_back_to_back();
        int w0;
        w0 = we_cnt;
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'd8; req_wdata = 32'h55;
        @(posedge CLK);
        #1;
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'd8; req_wdata = 32'h99;
        @(negedge CLK);
        n_checks++; if (ready !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL b2b_busy1 got ready=%b done=%b want 0/0", ready, done); end
        @(negedge CLK);
        n_checks++; if (ready !== 1'b0 || done !== 1'b1) begin
            n_fail++; $display("FAIL b2b_resp got ready=%b done=%b want 0/1", ready, done); end
        @(negedge CLK);
        n_checks++; if (ready !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle got ready=%b done=%b want 1/0", ready, done); end
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        @(negedge CLK);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_load_early got done=%b want 0", done); end
        @(negedge CLK);
        n_checks++; if (done !== 1'b1 || rdata !== 32'h55) begin
            n_fail++; $display("FAIL b2b_load got done=%b rdata=%h want 1/55", done, rdata); end
        n_checks++; if (we_cnt - w0 !== 1 || mem[2] !== 32'h55) begin
            n_fail++; $display("FAIL b2b_writes got n=%0d mem=%h want 1/55", we_cnt - w0, mem[2]); end
    endtask

    task automatic test_reset_mid_sb();
        int w0;
        mem[1] = 32'hCAFE_F00D;
        w0 = we_cnt;
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'd5; req_wdata = 32'hAB;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_busy got ready=%b want 0", ready); end
        RST = 1'b1;
        #1;
        n_checks++; if (ready !== 1'b1 || mem_WE !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset got ready=%b we=%b want 1/0", ready, mem_WE); end
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        n_checks++; if (mem[1] !== 32'hCAFE_F00D || we_cnt - w0 !== 0 || done !== 1'b0) begin
            n_fail++; $display("FAIL mid_no_write got mem=%h writes=%0d done=%b want cafef00d/0/0", mem[1], we_cnt - w0, done); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        test_reset();
        test_sw_lw();
        test_sb_rmw();
        test_loads();
        test_errors();
        test_back_to_back();
        test_reset_mid_sb();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
